axi_mem_port_arbiter: RTL and testbench
=======================================

# axi_mem_port_arbiter

Burst-granular arbiter that shares one single-port synchronous memory between the AXI read-burst engine and the AXI write-burst engine. It sits between the S_AXI conversion front end and the user memory.
- Accepts one burst command at a time from each engine.
- Grants the port round-robin and holds it for the whole burst.
- Generates per-beat memory addresses for FIXED/INCR bursts.
- Returns read data through a 2-entry buffer with backpressure.

## Interface
- DATA_WIDTH, 32, memory and beat data width
- ADDR_WIDTH, 8, word address width; depth 2**ADDR_WIDTH
- S_AXI_ACLK  in  1  sole clock, rising edge
- S_AXI_ARESETN  in  1  synchronous, active-low reset
- RD_REQ  in  1  read burst request; held with RD_ADDR/RD_LEN/RD_BURST until RD_GNT
- RD_ADDR  in  ADDR_WIDTH  first beat word address
- RD_LEN  in  8  beats minus one (0..255)
- RD_BURST  in  2  00 FIXED, 01 INCR, 10/11 handled as INCR
- RD_GNT  out  1  one-cycle pulse: read command accepted
- RD_DATA  out  DATA_WIDTH  read beat data (buffer head)
- RD_DVALID  out  1  buffer non-empty
- RD_DLAST  out  1  head beat is last of its burst
- RD_DREADY  in  1  pop head when RD_DVALID && RD_DREADY
- WR_REQ, WR_ADDR, WR_LEN, WR_BURST  in  1/ADDR_WIDTH/8/2  write command, same rules as read
- WR_GNT  out  1  one-cycle pulse: write command accepted
- WR_DATA  in  DATA_WIDTH  write beat data
- WR_DVALID  in  1  write beat valid
- WR_DREADY  out  1  high throughout WR_BURST state (combinational from state)
- WR_DONE  out  1  one-cycle pulse the cycle after the last write beat is written
- MEM_EN  out  1  memory access this cycle
- MEM_WE  out  1  write when MEM_EN
- MEM_ADDR  out  ADDR_WIDTH  access address
- MEM_WDATA  out  DATA_WIDTH  write data (= WR_DATA)
- MEM_RDATA  in  DATA_WIDTH  read data; valid exactly 1 cycle after a read access

## Operation
- State machine: IDLE, RD_BURST, WR_BURST.
- IDLE arbitration (priority):
  - Only one request: that requester wins.
  - Both requesting: the requester not granted last wins. last_grant resets to "write", so read wins the first tie.
- The winner's addr/len/burst are registered. Next cycle the FSM enters the burst state, the GNT pulse is high, and beat_idx=0.
- IDLE with no request: stay, no outputs.
- Beat address:
  - FIXED: start.
  - INCR: start + beat_idx, modulo 2**ADDR_WIDTH (0xFF+1 -> 0x00).
- RD_BURST: issue a read (MEM_EN=1, MEM_WE=0) at cycle t iff (buf_count + inflight − pop_t) < 2.
  - buf_count is 0..2; inflight=1 if a read was issued at t−1; pop_t=RD_DVALID&&RD_DREADY at t.
  - Each issued beat carries a last flag (beat_idx==len) into the buffer.
  - After issuing beat len: go to IDLE. Beats still in flight or buffered drain independently.
- WR_BURST: each cycle with WR_DVALID=1 → MEM_EN=1, MEM_WE=1, MEM_ADDR=beat address, MEM_WDATA=WR_DATA, same cycle.
  - After writing beat len: go to IDLE and pulse WR_DONE next cycle.
  - The engine's own WLAST is not used; length comes from WR_LEN.
- Read buffer: 2-entry FIFO of {data,last}.
  - Captures MEM_RDATA when inflight=1.
  - RD_DATA/RD_DLAST show the head; 0 when empty.
  - Push and pop in the same cycle are both honoured.
- Memory port: at most one access per cycle. Writes occur only in WR_BURST and reads only in RD_BURST, so no collision is possible.
- A write burst may start while read data is still draining from the buffer.

## Timing
- Reset (S_AXI_ARESETN=0 at a rising edge):
  - FSM=IDLE, last_grant=write, buffer emptied, inflight=0.
  - All outputs 0: RD_GNT, WR_GNT, RD_DATA, RD_DVALID, RD_DLAST, WR_DREADY, WR_DONE, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA.
- Reset mid-burst aborts the burst with no further memory accesses. MEM_RDATA arriving the cycle after reset is discarded.
- Grant latency: REQ sampled high in IDLE at cycle t → GNT high at t+1. The first memory access is possible at t+1.
- REQ still high at t+2 is treated as a new command, evaluated at the next IDLE.
- Read latency: issue at t → buffer entry at t+1 → RD_DVALID at t+1 earliest.
- Throughput with RD_DREADY held at 1:
  - One read beat per cycle.
  - A len=N read burst occupies the port N+1 cycles, plus one IDLE cycle between bursts.
- Write throughput: one beat per cycle while WR_DVALID=1. The FSM waits indefinitely in WR_BURST for WR_DVALID.

## Test plan
- Single read: RD_REQ, addr 0x10, len 3, INCR; mem[i]=i.
  - RD_GNT one cycle later.
  - MEM_ADDR 0x10..0x13 on consecutive cycles.
  - RD_DATA 0x10..0x13; RD_DLAST only on 0x13.
- FIXED write: WR_REQ, addr 0x20, len 2; WR_DATA A,B,C.
  - Three writes, all to 0x20; mem[0x20]=C.
  - WR_DONE pulses once, the cycle after C is written.
- Simultaneous requests from reset, repeated three times (each len 0):
  - Grant order is RD, WR, RD.
  - Never two MEM_EN accesses in one cycle.
- Read backpressure: len 7, RD_DREADY toggled 1/0 each cycle.
  - Buffer never exceeds 2 entries.
  - All 8 beats delivered in order, none dropped or duplicated.
- Address wrap: INCR read at 0xFE, len 3 → MEM_ADDR FE, FF, 00, 01.
- Reset mid-burst: reset after beat 2 of a len 7 read.
  - All outputs 0 the next cycle; buffer empty.
  - A new len 0 read afterwards returns the correct data.

Source files
------------

// File: rtl/axi_mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_mem_port_arbiter_if
//
// Bundle of every signal between the memory port arbiter, the two AXI burst
// engines (read and write) and the single-port user memory.
//
// Signal groups:
//   RD_*   read command, read grant and read beat data (buffer head)
//   WR_*   write command, write grant, write beat data and completion
//   MEM_*  single-port synchronous memory (read data one cycle after access)
//
// Modports:
//   slave  - the arbiter's view (commands and memory read data come in)
//   master - the engines' and memory's view (commands and read data go out)
// ---------------------------------------------------------------------------
interface axi_mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    // Read engine
    logic                  RD_REQ;
    logic [ADDR_WIDTH-1:0] RD_ADDR;
    logic [7:0]            RD_LEN;
    logic [1:0]            RD_BURST;
    logic                  RD_GNT;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_DVALID;
    logic                  RD_DLAST;
    logic                  RD_DREADY;

    // Write engine
    logic                  WR_REQ;
    logic [ADDR_WIDTH-1:0] WR_ADDR;
    logic [7:0]            WR_LEN;
    logic [1:0]            WR_BURST;
    logic                  WR_GNT;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_DVALID;
    logic                  WR_DREADY;
    logic                  WR_DONE;

    // Memory port
    logic                  MEM_EN;
    logic                  MEM_WE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_WDATA;
    logic [DATA_WIDTH-1:0] MEM_RDATA;

    modport slave (
        input  RD_REQ, RD_ADDR, RD_LEN, RD_BURST, RD_DREADY,
        output RD_GNT, RD_DATA, RD_DVALID, RD_DLAST,
        input  WR_REQ, WR_ADDR, WR_LEN, WR_BURST, WR_DATA, WR_DVALID,
        output WR_GNT, WR_DREADY, WR_DONE,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA
    );

    modport master (
        output RD_REQ, RD_ADDR, RD_LEN, RD_BURST, RD_DREADY,
        input  RD_GNT, RD_DATA, RD_DVALID, RD_DLAST,
        output WR_REQ, WR_ADDR, WR_LEN, WR_BURST, WR_DATA, WR_DVALID,
        input  WR_GNT, WR_DREADY, WR_DONE,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA
    );
endinterface

// File: rtl/axi_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_port_arbiter
//
// Shares one single-port synchronous memory between the AXI read-burst
// engine and the AXI write-burst engine. The port is granted round-robin at
// burst granularity and held for the whole burst. Per-beat addresses are
// generated for FIXED and INCR bursts (10/11 behave as INCR). Read data goes
// back through a 2-entry {data,last} buffer that honours RD_DREADY.
//
// Ports:
//   S_AXI_ACLK     sole clock, rising edge
//   S_AXI_ARESETN  synchronous active-low reset
//   bus            axi_mem_port_arbiter_if.slave (commands, beats, memory)
//   dbg_state      current FSM state (0 idle, 1 read burst, 2 write burst)
//
// Handshakes:
//   Commands: REQ is held with ADDR/LEN/BURST until the one-cycle GNT pulse;
//   the command is captured on the edge that raises GNT.
//   Read beats: a beat moves on every edge where RD_DVALID && RD_DREADY.
//   Write beats: a beat moves on every edge where WR_DVALID && WR_DREADY.
//   Memory: MEM_RDATA belongs to the read access of the previous cycle.
//
// DATA_WIDTH/ADDR_WIDTH must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module axi_mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    axi_mem_port_arbiter_if.slave      bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant_wr;   // 1: write engine was granted last
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  cmd_fixed;
    logic [7:0]            beat_idx;
    logic                  rd_gnt_q;
    logic                  wr_gnt_q;
    logic                  wr_done_q;

    // Read pipeline: one access in flight, two buffered results
    logic                  inflight;
    logic                  inflight_last;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  buf_wr_ptr;
    logic                  buf_rd_ptr;
    logic [1:0]            buf_count;

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  last_beat;
    logic                  rd_dvalid;
    logic                  rd_pop;
    logic                  rd_issue;
    logic                  wr_beat;
    logic                  mem_en;

    always_comb begin
        beat_addr = cmd_fixed ? cmd_addr : cmd_addr + ADDR_WIDTH'(beat_idx);
        last_beat = (beat_idx == cmd_len);
        rd_dvalid = (buf_count != 2'd0);
        rd_pop    = rd_dvalid && bus.RD_DREADY;
        // Issue only if the result is guaranteed a buffer slot next cycle,
        // counting the access already in flight and a pop happening now.
        rd_issue  = (state == ST_RD_BURST) &&
                    (({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, rd_pop}));
        wr_beat   = (state == ST_WR_BURST) && bus.WR_DVALID;
        mem_en    = rd_issue || wr_beat;
    end

    assign bus.MEM_EN    = mem_en;
    assign bus.MEM_WE    = wr_beat;
    assign bus.MEM_ADDR  = mem_en ? beat_addr : '0;
    assign bus.MEM_WDATA = wr_beat ? bus.WR_DATA : '0;

    assign bus.RD_DVALID = rd_dvalid;
    assign bus.RD_DATA   = rd_dvalid ? buf_data[buf_rd_ptr] : '0;
    assign bus.RD_DLAST  = rd_dvalid && buf_last[buf_rd_ptr];
    assign bus.RD_GNT    = rd_gnt_q;
    assign bus.WR_GNT    = wr_gnt_q;
    assign bus.WR_DONE   = wr_done_q;
    assign bus.WR_DREADY = (state == ST_WR_BURST);
    assign dbg_state     = state;

    // Arbitration and burst sequencing
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state         <= ST_IDLE;
            last_grant_wr <= 1'b1;
            cmd_addr      <= '0;
            cmd_len       <= '0;
            cmd_fixed     <= 1'b0;
            beat_idx      <= '0;
            rd_gnt_q      <= 1'b0;
            wr_gnt_q      <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            rd_gnt_q  <= 1'b0;
            wr_gnt_q  <= 1'b0;
            wr_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    beat_idx <= '0;
                    if (bus.RD_REQ && (!bus.WR_REQ || last_grant_wr)) begin
                        state         <= ST_RD_BURST;
                        cmd_addr      <= bus.RD_ADDR;
                        cmd_len       <= bus.RD_LEN;
                        cmd_fixed     <= (bus.RD_BURST == 2'b00);
                        rd_gnt_q      <= 1'b1;
                        last_grant_wr <= 1'b0;
                    end else if (bus.WR_REQ) begin
                        state         <= ST_WR_BURST;
                        cmd_addr      <= bus.WR_ADDR;
                        cmd_len       <= bus.WR_LEN;
                        cmd_fixed     <= (bus.WR_BURST == 2'b00);
                        wr_gnt_q      <= 1'b1;
                        last_grant_wr <= 1'b1;
                    end
                end
                ST_RD_BURST: begin
                    if (rd_issue) begin
                        if (last_beat) state <= ST_IDLE;
                        else           beat_idx <= beat_idx + 8'd1;
                    end
                end
                ST_WR_BURST: begin
                    if (wr_beat) begin
                        if (last_beat) begin
                            state     <= ST_IDLE;
                            wr_done_q <= 1'b1;
                        end else begin
                            beat_idx <= beat_idx + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read return buffer; pushes whatever the access of the previous cycle
    // returned, so a reset (which clears inflight) discards late data.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= '0;
            buf_wr_ptr    <= 1'b0;
            buf_rd_ptr    <= 1'b0;
            buf_count     <= '0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && last_beat;
            if (inflight) begin
                buf_data[buf_wr_ptr] <= bus.MEM_RDATA;
                buf_last[buf_wr_ptr] <= inflight_last;
                buf_wr_ptr           <= ~buf_wr_ptr;
            end
            if (rd_pop) buf_rd_ptr <= ~buf_rd_ptr;
            case ({inflight, rd_pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
module tb_axi_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    axi_mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus),
        .dbg_state     (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [256];
    logic          mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
            mem_ready <= 1'b1;
        end else if (bus.MEM_EN && bus.MEM_WE) begin
            mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
        end
        if (bus.MEM_EN && !bus.MEM_WE) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [DW:0]   exp_q [$];     // {last, data}
    logic [DW:0]   got_q [$];
    logic [AW-1:0] acc_addr_q [$];
    logic          acc_we_q [$];
    logic [DW-1:0] acc_wdata_q [$];
    int            acc_cyc_q [$];
    logic          gnt_q [$];     // 0 = read grant, 1 = write grant
    int            outstanding = 0;
    int            max_out = 0;
    int            done_cnt = 0;
    logic          both_gnt = 1'b0;
    int            cyc = 0;
    int            clr_id = 0;
    int            seen_clr = 0;

    // Monitor: samples each cycle well after the driver updates inputs
    always @(negedge clk) begin
        #2;
        cyc++;
        if (clr_id != seen_clr) begin
            seen_clr = clr_id;
            got_q.delete();
            acc_addr_q.delete();
            acc_we_q.delete();
            acc_wdata_q.delete();
            acc_cyc_q.delete();
            gnt_q.delete();
            outstanding = 0;
            max_out     = 0;
            done_cnt    = 0;
            both_gnt    = 1'b0;
        end
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (bus.MEM_EN) begin
                acc_addr_q.push_back(bus.MEM_ADDR);
                acc_we_q.push_back(bus.MEM_WE);
                acc_wdata_q.push_back(bus.MEM_WDATA);
                acc_cyc_q.push_back(cyc);
                if (!bus.MEM_WE) outstanding++;
            end
            if (bus.RD_DVALID && bus.RD_DREADY) begin
                got_q.push_back({bus.RD_DLAST, bus.RD_DATA});
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (bus.RD_GNT) gnt_q.push_back(1'b0);
            if (bus.WR_GNT) gnt_q.push_back(1'b1);
            if (bus.RD_GNT && bus.WR_GNT) both_gnt = 1'b1;
            if (bus.WR_DONE) done_cnt++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_got(input string tag);
        logic [DW:0] g;
        check($sformatf("%s_cnt", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = 'x;
            if (i < got_q.size()) g = got_q[i];
            check($sformatf("%s_beat%0d", tag, i), 64'(g), 64'(exp_q[i]));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flags"}, 64'({bus.RD_GNT, bus.WR_GNT, bus.RD_DVALID, bus.RD_DLAST,
                                    bus.WR_DREADY, bus.WR_DONE, bus.MEM_EN, bus.MEM_WE}), 64'd0);
        check({tag, "_rd_data"},   64'(bus.RD_DATA),   64'd0);
        check({tag, "_mem_addr"},  64'(bus.MEM_ADDR),  64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.MEM_WDATA), 64'd0);
        check({tag, "_state"},     64'(dbg_state),     64'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.RD_REQ = 1'b0; bus.RD_ADDR = '0; bus.RD_LEN = '0; bus.RD_BURST = '0;
        bus.RD_DREADY = 1'b0;
        bus.WR_REQ = 1'b0; bus.WR_ADDR = '0; bus.WR_LEN = '0; bus.WR_BURST = '0;
        bus.WR_DATA = '0; bus.WR_DVALID = 1'b0;
    endtask

    task automatic clear_mon();
        clr_id++;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic read_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                            output int lat);
        bus.RD_ADDR = a; bus.RD_LEN = l; bus.RD_BURST = b; bus.RD_REQ = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.RD_GNT) begin
                lat = i;
                break;
            end
        end
        bus.RD_REQ = 1'b0;
    endtask

    task automatic write_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                             output int lat);
        bus.WR_ADDR = a; bus.WR_LEN = l; bus.WR_BURST = b; bus.WR_REQ = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.WR_GNT) begin
                lat = i;
                break;
            end
        end
        bus.WR_REQ = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [AW-1:0] wrap_addr [4];

        idle_inputs();
        do_reset();

        // Single INCR read 0x10 len 3
        clear_mon();
        bus.RD_DREADY = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), DW'(32'h10 + i)});
        read_cmd(8'h10, 8'd3, 2'b01, lat);
        check("t1_gnt_latency", 64'(lat), 64'd1);
        check("t1_state_rd", 64'(dbg_state), 64'd1);
        wait_got(4, 20);
        check_got("t1");
        check("t1_acc_cnt", 64'(acc_addr_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_addr_q.size(); i++) begin
            check($sformatf("t1_addr%0d", i), 64'(acc_addr_q[i]), 64'(8'h10 + i));
            check($sformatf("t1_we%0d", i), 64'(acc_we_q[i]), 64'd0);
            check($sformatf("t1_cyc%0d", i), 64'(acc_cyc_q[i] - acc_cyc_q[0]), 64'(i));
        end
        #1;
        check("t1_empty_valid", 64'(bus.RD_DVALID), 64'd0);
        check("t1_empty_data", 64'(bus.RD_DATA), 64'd0);

        // FIXED write 0x20 len 2 with one stall cycle
        clear_mon();
        write_cmd(8'h20, 8'd2, 2'b00, lat);
        check("t2_gnt_latency", 64'(lat), 64'd1);
        check("t2_wready", 64'(bus.WR_DREADY), 64'd1);
        bus.WR_DVALID = 1'b1; bus.WR_DATA = 32'hA0A0_0001;
        @(negedge clk); bus.WR_DVALID = 1'b0;
        @(negedge clk); bus.WR_DVALID = 1'b1; bus.WR_DATA = 32'hB0B0_0002;
        @(negedge clk); bus.WR_DATA = 32'hC0C0_0003;
        @(negedge clk); bus.WR_DVALID = 1'b0; bus.WR_DATA = '0;
        #1;
        check("t2_done_pulse", 64'(bus.WR_DONE), 64'd1);
        check("t2_wready_off", 64'(bus.WR_DREADY), 64'd0);
        @(negedge clk); #1;
        check("t2_done_low", 64'(bus.WR_DONE), 64'd0);
        @(negedge clk);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);
        check("t2_acc_cnt", 64'(acc_addr_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < acc_addr_q.size(); i++) begin
            check($sformatf("t2_addr%0d", i), 64'(acc_addr_q[i]), 64'h20);
            check($sformatf("t2_we%0d", i), 64'(acc_we_q[i]), 64'd1);
        end
        if (acc_wdata_q.size() == 3) begin
            check("t2_wdata0", 64'(acc_wdata_q[0]), 64'hA0A0_0001);
            check("t2_wdata1", 64'(acc_wdata_q[1]), 64'hB0B0_0002);
            check("t2_wdata2", 64'(acc_wdata_q[2]), 64'hC0C0_0003);
        end
        check("t2_mem20", 64'(mem[8'h20]), 64'hC0C0_0003);

        // Simultaneous requests from reset, both held: RD, WR, RD
        do_reset();
        clear_mon();
        bus.RD_DREADY = 1'b1;
        bus.RD_ADDR = 8'h30; bus.RD_LEN = 8'd0; bus.RD_BURST = 2'b01; bus.RD_REQ = 1'b1;
        bus.WR_ADDR = 8'h31; bus.WR_LEN = 8'd0; bus.WR_BURST = 2'b01; bus.WR_REQ = 1'b1;
        bus.WR_DATA = 32'h0000_00D0; bus.WR_DVALID = 1'b1;
        for (int i = 0; i < 20 && gnt_q.size() < 3; i++) @(negedge clk);
        idle_inputs();
        bus.RD_DREADY = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_gnt_cnt", 64'(gnt_q.size()), 64'd3);
        if (gnt_q.size() == 3) begin
            check("t3_gnt0_rd", 64'(gnt_q[0]), 64'd0);
            check("t3_gnt1_wr", 64'(gnt_q[1]), 64'd1);
            check("t3_gnt2_rd", 64'(gnt_q[2]), 64'd0);
        end
        check("t3_no_dual_gnt", 64'(both_gnt), 64'd0);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);
        check("t3_mem31", 64'(mem[8'h31]), 64'hD0);
        exp_q.push_back({1'b1, DW'(32'h30)});
        exp_q.push_back({1'b1, DW'(32'h30)});
        check_got("t3");

        // Read backpressure: len 7, RD_DREADY toggling
        clear_mon();
        bus.RD_DREADY = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), DW'(32'h40 + i)});
        read_cmd(8'h40, 8'd7, 2'b01, lat);
        check("t4_gnt_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 80 && got_q.size() < 8; i++) begin
            @(negedge clk);
            bus.RD_DREADY = ~bus.RD_DREADY;
        end
        bus.RD_DREADY = 1'b1;
        repeat (3) @(negedge clk);
        check_got("t4");
        check("t4_buf_le2", 64'(max_out <= 2), 64'd1);

        // INCR address wrap at 0xFE
        clear_mon();
        wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00; wrap_addr[3] = 8'h01;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), DW'(wrap_addr[i])});
        read_cmd(8'hFE, 8'd3, 2'b01, lat);
        wait_got(4, 20);
        check("t5_acc_cnt", 64'(acc_addr_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_addr_q.size(); i++)
            check($sformatf("t5_addr%0d", i), 64'(acc_addr_q[i]), 64'(wrap_addr[i]));
        check_got("t5");

        // Reset in the middle of a len 7 read
        clear_mon();
        read_cmd(8'h50, 8'd7, 2'b01, lat);
        check("t6_gnt_latency", 64'(lat), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.RD_DREADY = 1'b1;
        @(negedge clk); #1;
        check_outputs_zero("t6_after_reset");
        rst_n = 1'b1;
        clear_mon();
        @(negedge clk); #1;
        check("t6_buf_empty", 64'(bus.RD_DVALID), 64'd0);
        check("t6_no_access", 64'(bus.MEM_EN), 64'd0);
        exp_q.push_back({1'b1, DW'(32'h55)});
        read_cmd(8'h55, 8'd0, 2'b01, lat);
        check("t6b_gnt_latency", 64'(lat), 64'd1);
        wait_got(1, 20);
        check_got("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
